spislave: RTL and testbench
===========================

# spislave

SPI mode-0 responder peripheral: the target end of the `mosi`/`msck`/`miso` link that `sdcardio` drives as master. It lets a second p601zero board, or any external SPI master, exchange bytes with the 6801 CPU. It sits on the CPU peripheral bus like `uartio`, decoded in the DS6/DS7 window, and raises a maskable IRQ that is ORed into `sys_irq`. External SPI pins are oversampled by `clk`; there is no second clock domain.

## Interface
- `AW`, 2: CPU register address width.
- `DUMMY_RST`, 8'hFF: reset value of the DUMMY register.

- `clk` in 1: system clock (`sys_clk`). All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `irq` out 1: interrupt request, level, active-high.
- `AD` in AW: register select.
- `DI` in 8: write data from the CPU.
- `DO` out 8: read data to the CPU.
- `rw` in 1: 1 = read, 0 = write.
- `cs` in 1: chip select, already qualified with `vma`.
- `spi_cs_n` in 1: SPI select from the external master, active-low, asynchronous.
- `spi_sck` in 1: SPI clock, asynchronous, idle low.
- `spi_mosi` in 1: SPI data in.
- `spi_miso` out 1: SPI data out.
- `spi_miso_oe` out 1: output enable for the `spi_miso` pad.

## Operation
- Registers. DO is combinational from AD whenever `cs` is high. Side effects happen on the clk edge when `cs` is high.
  - 0 DATA:
    - Read returns RXBUF and clears RXF.
    - Write loads TXHOLD and clears TXE.
  - 1 STATUS (read):
    - b0 RXF, b1 TXE, b2 OVR, b3 UND, b4 BUSY (synced `spi_cs_n` is low). Bits b7..5 read 0.
  - 1 STATUS (write):
    - Writing 1 to b2 clears OVR.
    - Writing 1 to b3 clears UND.
  - 2 CTRL (read/write):
    - b0 RXIE, b1 TXIE, b2 ERRIE.
    - b7 EN. When EN=0, the SPI pins are ignored and `spi_miso_oe` is 0.
  - 3 DUMMY (read/write): byte shifted out when TXHOLD is empty.
- `irq` = (RXF&RXIE) | (TXE&TXIE) | ((OVR|UND)&ERRIE), computed combinationally from registers.
- Synchronizers: two flops each on `spi_cs_n`, `spi_sck` and `spi_mosi`. SCK edges are detected from the synced value and its previous value.
- FSM states:
  - IDLE: `spi_miso_oe`=0.
    - Synced cs_n falling with EN=1 → LOAD.
  - LOAD (1 clk): TXSHIFT is loaded from TXHOLD if TXE=0, then TXE is set to 1. Otherwise it is loaded from DUMMY and UND is set to 1. Then BITCNT=0, `spi_miso_oe`=1, `spi_miso`=TXSHIFT[7] → SHIFT.
  - SHIFT: on SCK rise, RXSHIFT = {RXSHIFT[6:0], mosi}.
    - If BITCNT=7: the byte is complete. If RXF=0, RXBUF←byte and RXF=1. If RXF=1, RXBUF is kept, OVR=1, and the byte is dropped. BITCNT→0 and the FSM goes to RELOAD_WAIT.
    - Otherwise BITCNT+1.
    - On SCK fall, TXSHIFT shifts left and `spi_miso` takes the new MSB.
  - RELOAD_WAIT: on SCK fall, perform the LOAD action, then go to SHIFT.
  - Any state: synced cs_n high → IDLE. The partial byte is discarded, BITCNT=0, and RXF/RXBUF are unchanged.
- Simultaneous events:
  - A CPU DATA read in the same clk as a byte completing: the read returns the old RXBUF, the new byte is stored, RXF stays 1, and OVR is not set.
  - A CPU DATA write in the same clk as LOAD/RELOAD: the reload uses DUMMY (TXE was 1) and sets UND. The written byte remains in TXHOLD with TXE=0 for the next byte.
  - A CPU write of 1 to STATUS b2/b3 in the same clk as the matching set event: set wins.
- Clearing EN mid-frame forces IDLE.

## Timing
- Reset values:
  - Outputs: `irq`=0, `spi_miso`=0, `spi_miso_oe`=0.
  - Registers: RXBUF=0, TXHOLD=0, RXF=0, TXE=1, OVR=0, UND=0, CTRL=0, DUMMY=DUMMY_RST.
  - FSM: IDLE.
- Pin-to-detect latency: 3 clk (2 sync flops plus 1 edge register).
- `spi_miso` updates 3 clk after the SCK fall. First MSB is valid 4 clk after the cs_n fall.
- Allowed SPI rates:
  - SCK high and low times must each be at least 4 clk, so SCK ≤ clk/8 (750 kHz at 6 MHz).
  - Master cs_n-low to first SCK rise must be at least 5 clk.
- RXF is set 3 clk after the 8th SCK rise. It is visible to the CPU in the next cycle.

## Test plan
- EN=1, write TXHOLD=0xA5. Master sends 0x3C at clk/8. Expected: master receives 0xA5; RXBUF=0x3C; STATUS reads 0x13 (RXF, TXE, BUSY) before cs_n rises; a DATA read returns 0x3C and STATUS b0 goes to 0.
- TXHOLD empty, DUMMY=0x5A, master sends one byte. Expected: master receives 0x5A; UND=1; `irq`=1 with ERRIE=1; writing 0x08 to STATUS clears UND.
- Master sends two bytes 0x11, 0x22 without a CPU read. Expected: RXBUF=0x11, OVR=1, RXF=1.
- cs_n deasserted after 5 bits. Expected: RXF unchanged, `spi_miso_oe`=0 3 clk later. A following full byte 0x81 is received correctly.
- Reset asserted mid-byte. Expected: all reset values return in the next clk and the FSM is IDLE. Reset deasserted with cs_n still low: no transfer until cs_n goes high and then falls again.
- CPU DATA read coincident with the 8th-bit completion. Expected: the read returns the old byte, RXF stays 1, OVR stays 0.

Source files
------------

// File: rtl/spislave.sv
// SPI mode-0 target on the 6801 peripheral bus. External SPI pins are oversampled
// by clk through two-flop synchronizers; bytes are exchanged via DATA/STATUS/CTRL/DUMMY.
module spislave #(
  parameter int         AW        = 2,
  parameter logic [7:0] DUMMY_RST = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          irq,
  input  logic [AW-1:0] AD,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  input  logic          rw,
  input  logic          cs,
  input  logic          spi_cs_n,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_RELOAD
  } state_t;

  state_t     state_reg;
  logic [2:0] pin_vec;
  logic [2:0] meta_reg;
  logic [2:0] sync_reg;
  logic       cs_n_prev_reg;
  logic       sck_prev_reg;
  logic       cs_n_sync;
  logic       sck_sync;
  logic       mosi_sync;
  logic       cs_fall;
  logic       sck_rise;
  logic       sck_fall;

  logic [7:0] rxbuf_reg;
  logic [7:0] txhold_reg;
  logic [7:0] dummy_reg;
  logic [7:0] txshift_reg;
  logic [7:0] rxshift_reg;
  logic [2:0] bitcnt_reg;
  logic       rxf_reg;
  logic       txe_reg;
  logic       ovr_reg;
  logic       und_reg;
  logic       rxie_reg;
  logic       txie_reg;
  logic       errie_reg;
  logic       en_reg;

  logic       sel_data;
  logic       sel_stat;
  logic       sel_ctrl;
  logic       sel_dummy;
  logic       data_rd;
  logic       data_wr;
  logic       stat_wr;
  logic       ctrl_wr;
  logic       dummy_wr;
  logic       abort;
  logic       load_now;
  logic [7:0] load_data;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       rx_store;
  logic       ovr_set;

  // Synchronizers reset to "selected" so a cs_n held low across reset never
  // looks like a fresh falling edge; a new transfer needs cs_n high first.
  assign pin_vec = {spi_mosi, spi_sck, spi_cs_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg      <= 3'b000;
      sync_reg      <= 3'b000;
      cs_n_prev_reg <= 1'b0;
      sck_prev_reg  <= 1'b0;
    end else begin
      meta_reg      <= pin_vec;
      sync_reg      <= meta_reg;
      cs_n_prev_reg <= sync_reg[0];
      sck_prev_reg  <= sync_reg[1];
    end
  end

  assign cs_n_sync = sync_reg[0];
  assign sck_sync  = sync_reg[1];
  assign mosi_sync = sync_reg[2];
  assign cs_fall   = cs_n_prev_reg & ~cs_n_sync;
  assign sck_rise  = sck_sync & ~sck_prev_reg;
  assign sck_fall  = ~sck_sync & sck_prev_reg;

  assign sel_data  = (AD == AW'(0));
  assign sel_stat  = (AD == AW'(1));
  assign sel_ctrl  = (AD == AW'(2));
  assign sel_dummy = (AD == AW'(3));
  assign data_rd   = cs & rw & sel_data;
  assign data_wr   = cs & ~rw & sel_data;
  assign stat_wr   = cs & ~rw & sel_stat;
  assign ctrl_wr   = cs & ~rw & sel_ctrl;
  assign dummy_wr  = cs & ~rw & sel_dummy;

  assign abort     = cs_n_sync | ~en_reg;
  assign load_now  = ~abort & ((state_reg == ST_LOAD) ||
                               ((state_reg == ST_RELOAD) && sck_fall));
  assign load_data = txe_reg ? dummy_reg : txhold_reg;
  assign rx_byte   = {rxshift_reg[6:0], mosi_sync};
  assign byte_done = ~abort && (state_reg == ST_SHIFT) && sck_rise && (bitcnt_reg == 3'd7);
  // A DATA read in the same cycle frees RXBUF, so the new byte is taken without overrun.
  assign rx_store  = byte_done & (~rxf_reg | data_rd);
  assign ovr_set   = byte_done & rxf_reg & ~data_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rxbuf_reg   <= 8'h00;
      txhold_reg  <= 8'h00;
      dummy_reg   <= DUMMY_RST;
      txshift_reg <= 8'h00;
      rxshift_reg <= 8'h00;
      bitcnt_reg  <= 3'd0;
      rxf_reg     <= 1'b0;
      txe_reg     <= 1'b1;
      ovr_reg     <= 1'b0;
      und_reg     <= 1'b0;
      rxie_reg    <= 1'b0;
      txie_reg    <= 1'b0;
      errie_reg   <= 1'b0;
      en_reg      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_reg    <= DI[7];
        errie_reg <= DI[2];
        txie_reg  <= DI[1];
        rxie_reg  <= DI[0];
      end
      if (dummy_wr) begin
        dummy_reg <= DI;
      end

      // A CPU write always leaves a fresh byte pending, even if a load happens now.
      if (data_wr) begin
        txhold_reg <= DI;
        txe_reg    <= 1'b0;
      end else if (load_now && !txe_reg) begin
        txe_reg <= 1'b1;
      end

      if (load_now && txe_reg) begin
        und_reg <= 1'b1;
      end else if (stat_wr && DI[3]) begin
        und_reg <= 1'b0;
      end

      if (ovr_set) begin
        ovr_reg <= 1'b1;
      end else if (stat_wr && DI[2]) begin
        ovr_reg <= 1'b0;
      end

      if (rx_store) begin
        rxbuf_reg <= rx_byte;
        rxf_reg   <= 1'b1;
      end else if (data_rd) begin
        rxf_reg <= 1'b0;
      end

      if ((state_reg != ST_IDLE) && abort) begin
        state_reg   <= ST_IDLE;
        bitcnt_reg  <= 3'd0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            spi_miso_oe <= 1'b0;
            if (cs_fall && en_reg) begin
              state_reg <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            txshift_reg <= load_data;
            spi_miso    <= load_data[7];
            spi_miso_oe <= 1'b1;
            bitcnt_reg  <= 3'd0;
            state_reg   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (sck_rise) begin
              rxshift_reg <= rx_byte;
              if (bitcnt_reg == 3'd7) begin
                bitcnt_reg <= 3'd0;
                state_reg  <= ST_RELOAD;
              end else begin
                bitcnt_reg <= bitcnt_reg + 3'd1;
              end
            end else if (sck_fall) begin
              txshift_reg <= {txshift_reg[6:0], 1'b0};
              spi_miso    <= txshift_reg[6];
            end
          end
          ST_RELOAD: begin
            // The falling edge after bit 7 presents the next byte's MSB.
            if (sck_fall) begin
              txshift_reg <= load_data;
              spi_miso    <= load_data[7];
              bitcnt_reg  <= 3'd0;
              state_reg   <= ST_SHIFT;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    DO = 8'h00;
    if (cs) begin
      if (sel_data) begin
        DO = rxbuf_reg;
      end else if (sel_stat) begin
        DO = {3'b000, ~cs_n_sync, und_reg, ovr_reg, txe_reg, rxf_reg};
      end else if (sel_ctrl) begin
        DO = {en_reg, 4'b0000, errie_reg, txie_reg, rxie_reg};
      end else if (sel_dummy) begin
        DO = dummy_reg;
      end
    end
  end

  assign irq = (rxf_reg & rxie_reg) | (txe_reg & txie_reg) | ((ovr_reg | und_reg) & errie_reg);

endmodule

// File: tb/tb_spislave.sv
// Directed bench for spislave: a behavioural SPI master at clk/8 plus CPU bus tasks.
module tb_spislave;

  logic       clk = 1'b0;
  logic       rst;
  logic       irq;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spislave #(.AW(2), .DUMMY_RST(8'hFF)) dut (
    .clk(clk), .rst(rst), .irq(irq), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic frame_start();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk);
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Mode-0 master: 4 clk low, sample MISO and rise, 4 clk high, fall.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit hold_high,
                          input bit rd_at_done, output logic [7:0] rx, output logic [7:0] rd_val);
    rx = 8'h00;
    rd_val = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      if (i == nbits - 1 && rd_at_done) begin
        repeat (2) @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = 2'd0;
        #1 rd_val = DO;
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      if (!(i == nbits - 1 && hold_high)) spi_sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_rxbuf got=%h exp=00", d); end
    cpu_read(2'd2, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", d); end
    cpu_read(2'd3, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL reset_dummy got=%h exp=ff", d); end
    repeat (3) @(negedge clk);
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL reset_status got=%h exp=02", d); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] rx, rv, d;
    cpu_write(2'd2, 8'h80);
    cpu_write(2'd0, 8'hA5);
    frame_start();
    spi_xfer(8'h3C, 8, 1'b1, 1'b0, rx, rv);
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h13) begin failures++; $display("FAIL basic_status_busy got=%h exp=13", d); end
    frame_end();
    checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL basic_master_rx got=%h exp=a5", rx); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h3C) begin failures++; $display("FAIL basic_rxbuf got=%h exp=3c", d); end
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL basic_rxf_cleared got=%h exp=02", d); end
    $display("test_basic master_rx=%h", rx);
  endtask

  task automatic test_underrun();
    logic [7:0] rx, rv, d;
    cpu_write(2'd2, 8'h84);
    cpu_write(2'd3, 8'h5A);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL und_irq_before got=%b exp=0", irq); end
    frame_start();
    spi_xfer(8'h77, 8, 1'b1, 1'b0, rx, rv);
    frame_end();
    checks++; if (rx !== 8'h5A) begin failures++; $display("FAIL und_master_rx got=%h exp=5a", rx); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL und_irq got=%b exp=1", irq); end
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h0B) begin failures++; $display("FAIL und_status got=%h exp=0b", d); end
    cpu_write(2'd1, 8'h08);
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL und_clear got=%h exp=03", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL und_irq_after got=%b exp=0", irq); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL und_rxbuf got=%h exp=77", d); end
    $display("test_underrun master_rx=%h", rx);
  endtask

  task automatic test_overrun();
    logic [7:0] rx1, rx2, rv, d;
    frame_start();
    spi_xfer(8'h11, 8, 1'b0, 1'b0, rx1, rv);
    spi_xfer(8'h22, 8, 1'b1, 1'b0, rx2, rv);
    frame_end();
    checks++; if (rx2 !== 8'h5A) begin failures++; $display("FAIL ovr_master_rx2 got=%h exp=5a", rx2); end
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL ovr_status got=%h exp=0f", d); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL ovr_rxbuf got=%h exp=11", d); end
    cpu_write(2'd1, 8'h0C);
    cpu_read(2'd1, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL ovr_clear got=%h exp=02", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovr_irq_after got=%b exp=0", irq); end
    $display("test_overrun master_rx=%h,%h", rx1, rx2);
  endtask

  task automatic test_abort();
    logic [7:0] rx, rv, d;
    cpu_write(2'd2, 8'h80);
    cpu_write(2'd0, 8'h96);
    frame_start();
    spi_xfer(8'hF0, 5, 1'b0, 1'b0, rx, rv);
    checks++; if (rx[4:0] !== 5'b10010) begin failures++; $display("FAIL abort_partial_rx got=%b exp=10010", rx[4:0]); end
    @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL abort_oe_early got=%b exp=1", spi_miso_oe); end
    @(negedge clk);
    checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL abort_oe_off got=%b exp=0", spi_miso_oe); end
    repeat (3) @(negedge clk);
    cpu_read(2'd1, d);
    checks++; if (d[0] !== 1'b0) begin failures++; $display("FAIL abort_rxf got=%b exp=0", d[0]); end
    cpu_write(2'd0, 8'hC3);
    frame_start();
    spi_xfer(8'h81, 8, 1'b1, 1'b0, rx, rv);
    frame_end();
    checks++; if (rx !== 8'hC3) begin failures++; $display("FAIL abort_next_master_rx got=%h exp=c3", rx); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h81) begin failures++; $display("FAIL abort_next_rxbuf got=%h exp=81", d); end
    cpu_write(2'd1, 8'h0C);
    $display("test_abort master_rx=%h", rx);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx, rv, d;
    frame_start();
    spi_xfer(8'h55, 8, 1'b1, 1'b0, rx, rv);
    frame_end();
    frame_start();
    spi_xfer(8'hAA, 8, 1'b1, 1'b1, rx, rv);
    frame_end();
    checks++; if (rv !== 8'h55) begin failures++; $display("FAIL coinc_read_old got=%h exp=55", rv); end
    cpu_read(2'd1, d);
    checks++; if ((d & 8'h05) !== 8'h01) begin failures++; $display("FAIL coinc_rxf_ovr got=%h exp=01", d & 8'h05); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'hAA) begin failures++; $display("FAIL coinc_new_byte got=%h exp=aa", d); end
    cpu_write(2'd1, 8'h0C);
    $display("test_back_to_back coincident_read=%h", rv);
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] rx, rv, d;
    cpu_write(2'd2, 8'h87);
    cpu_write(2'd0, 8'hE7);
    frame_start();
    spi_xfer(8'hFF, 3, 1'b0, 1'b0, rx, rv);
    checks++; if (spi_miso_oe !== 1'b1) begin failures++; $display("FAIL rstmid_oe_before got=%b exp=1", spi_miso_oe); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe got=%b exp=0", spi_miso_oe); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
    cpu_read(2'd1, d);
    checks++; if ((d & 8'h0F) !== 8'h02) begin failures++; $display("FAIL rstmid_status got=%h exp=02", d & 8'h0F); end
    cpu_read(2'd2, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_ctrl got=%h exp=00", d); end
    cpu_write(2'd2, 8'h80);
    spi_xfer(8'h99, 8, 1'b1, 1'b0, rx, rv);
    checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_no_xfer_oe got=%b exp=0", spi_miso_oe); end
    cpu_read(2'd1, d);
    checks++; if (d[0] !== 1'b0) begin failures++; $display("FAIL rstmid_no_xfer_rxf got=%b exp=0", d[0]); end
    frame_end();
    cpu_write(2'd0, 8'h6D);
    frame_start();
    spi_xfer(8'h42, 8, 1'b1, 1'b0, rx, rv);
    frame_end();
    checks++; if (rx !== 8'h6D) begin failures++; $display("FAIL rstmid_after_master_rx got=%h exp=6d", rx); end
    cpu_read(2'd0, d);
    checks++; if (d !== 8'h42) begin failures++; $display("FAIL rstmid_after_rxbuf got=%h exp=42", d); end
    $display("test_reset_midbyte master_rx=%h", rx);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 2'd0; DI = 8'h00;
    spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_midbyte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
